// File: rtl/multiplier_taint_pkg.sv
// Shared definitions for the taint-tracking shift-add multiplier (datapath and control).
// Taint helpers work on a fixed wide vector; callers zero-extend and keep the low bits.
package multiplier_taint_pkg;

  localparam int WIDTH = 4;
  // Widest vector the taint helpers handle; covers rs (2*WIDTH+1) for WIDTH up to 31.
  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0] taint_vec_t;

  typedef enum logic [1:0] {
    RS_HOLD  = 2'd0,
    RS_SHIFT = 2'd1,
    RS_LOAD  = 2'd2,
    RS_CLEAR = 2'd3
  } rs_op_e;

  // Taint of an add: sum bit k may depend on every operand bit at or below k.
  function automatic taint_vec_t prefix_or(input taint_vec_t t);
    taint_vec_t r;
    r[0] = t[0];
    for (int k = 1; k < MAX_W; k++) begin
      r[k] = r[k-1] | t[k];
    end
    return r;
  endfunction

  // Contribution of one mux alternative: if its select is tainted, every bit where it
  // differs from the chosen value, plus its own taint, becomes tainted.
  function automatic taint_vec_t mux_taint(input taint_vec_t chosen,
                                           input taint_vec_t alt,
                                           input taint_vec_t alt_t,
                                           input logic       sel_t);
    return sel_t ? ((alt ^ chosen) | alt_t) : '0;
  endfunction

endpackage

// File: rtl/taint_enable_reg.sv
// Enable register with a taint shadow; a tainted enable taints every bit the load
// could have changed.
module taint_enable_reg
  import multiplier_taint_pkg::*;
#(
  parameter int WIDTH = multiplier_taint_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             en_t,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] d_t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_t
);

  logic [WIDTH-1:0] chosen, chosen_t, alt, alt_t, next_t;
  logic [MAX_W-1:WIDTH] unused_hi;

  // NOTE: every variable assigned in always_comb gets a value on every path (defaults or
  // full if/else), otherwise synthesis infers a latch.
  always_comb begin
    chosen   = en ? d   : q;
    chosen_t = en ? d_t : q_t;
    alt      = en ? q   : d;
    alt_t    = en ? q_t : d_t;
    {unused_hi, next_t} = taint_vec_t'(chosen_t)
                        | mux_taint(taint_vec_t'(chosen), taint_vec_t'(alt),
                                    taint_vec_t'(alt_t), en_t);
  end

  // NOTE: state is written with non-blocking assignments so every flop samples the
  // pre-edge values; reset is synchronous here, checked only at the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      q_t <= '0;
    end else begin
      q   <= chosen;
      q_t <= next_t;
    end
  end

endmodule

// File: rtl/multiplier_datapath_taint_track_bitwise.sv
// Datapath of the sequential shift-add multiplier: md/mr operand registers and the
// rs = {c, hi, lo} result shift register, each with a bitwise taint shadow.
module multiplier_datapath_taint_track_bitwise
  import multiplier_taint_pkg::*;
#(
  parameter int WIDTH = multiplier_taint_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplicand_t,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplier_t,
  input  logic               mdld,
  input  logic               mdld_t,
  input  logic               mrld,
  input  logic               mrld_t,
  input  logic               rsclear,
  input  logic               rsclear_t,
  input  logic               rsload,
  input  logic               rsload_t,
  input  logic               rsshr,
  input  logic               rsshr_t,
  output logic [WIDTH-1:0]   multiplierReg,
  output logic [WIDTH-1:0]   multiplierReg_t,
  output logic [2*WIDTH-1:0] product,
  output logic [2*WIDTH-1:0] product_t
);

  localparam int RW = 2 * WIDTH + 1;

  logic [WIDTH-1:0] md_q, md_t_q;

  taint_enable_reg #(.WIDTH(WIDTH)) u_md (
    .clk  (clk),
    .rst  (rst),
    .en   (mdld),
    .en_t (mdld_t),
    .d    (multiplicand),
    .d_t  (multiplicand_t),
    .q    (md_q),
    .q_t  (md_t_q)
  );

  taint_enable_reg #(.WIDTH(WIDTH)) u_mr (
    .clk  (clk),
    .rst  (rst),
    .en   (mrld),
    .en_t (mrld_t),
    .d    (multiplier),
    .d_t  (multiplier_t),
    .q    (multiplierReg),
    .q_t  (multiplierReg_t)
  );

  logic [RW-1:0]    rs_q, rs_t_q, rs_d, rs_t_d;
  logic [RW-1:0]    load_val, load_t, shift_val, shift_t;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] add_t;
  logic [MAX_W-1:WIDTH] unused_pre;
  logic [MAX_W-1:RW]    unused_acc;
  logic             hold_sel_t;
  rs_op_e           rs_op;

  // Candidate next values for rs; the add keeps its carry in c so nothing is lost.
  always_comb begin
    sum = {1'b0, rs_q[2*WIDTH-1:WIDTH]} + {1'b0, md_q};
    {unused_pre, add_t} = prefix_or(taint_vec_t'(rs_t_q[2*WIDTH-1:WIDTH] | md_t_q));
    load_val  = {sum, rs_q[WIDTH-1:0]};
    load_t    = {add_t[WIDTH-1], add_t, rs_t_q[WIDTH-1:0]};
    shift_val = rs_q >> 1;
    shift_t   = rs_t_q >> 1;
  end

  always_comb begin
    rs_op = RS_HOLD;
    if (rsclear)     rs_op = RS_CLEAR;
    else if (rsload) rs_op = RS_LOAD;
    else if (rsshr)  rs_op = RS_SHIFT;

    rs_d   = rs_q;
    rs_t_d = rs_t_q;
    case (rs_op)
      RS_CLEAR: begin rs_d = '0;        rs_t_d = '0;      end
      RS_LOAD:  begin rs_d = load_val;  rs_t_d = load_t;  end
      RS_SHIFT: begin rs_d = shift_val; rs_t_d = shift_t; end
      default:  begin rs_d = rs_q;      rs_t_d = rs_t_q;  end
    endcase

    // Whether hold wins depends on every command, so any tainted command taints it.
    hold_sel_t = rsclear_t | rsload_t | rsshr_t;
    {unused_acc, rs_t_d} = taint_vec_t'(rs_t_d)
      | mux_taint(taint_vec_t'(rs_d), '0, '0, rsclear_t)
      | mux_taint(taint_vec_t'(rs_d), taint_vec_t'(load_val),  taint_vec_t'(load_t),  rsload_t)
      | mux_taint(taint_vec_t'(rs_d), taint_vec_t'(shift_val), taint_vec_t'(shift_t), rsshr_t)
      | mux_taint(taint_vec_t'(rs_d), taint_vec_t'(rs_q),      taint_vec_t'(rs_t_q),  hold_sel_t);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_q   <= '0;
      rs_t_q <= '0;
    end else begin
      rs_q   <= rs_d;
      rs_t_q <= rs_t_d;
    end
  end

  assign product   = rs_q[2*WIDTH-1:0];
  assign product_t = rs_t_q[2*WIDTH-1:0];

endmodule
